// File: rtl/exe_stage_module_pkg.sv
// Shared execute-stage encodings: ALU commands, shift types, forward selects,
// NZCV bit positions and default datapath widths.
package exe_stage_module_pkg;

  // Default datapath widths
  localparam int unsigned EXE_W_REG     = 32;
  localparam int unsigned EXE_W_ADDR    = 32;
  localparam int unsigned EXE_W_IMM24   = 24;
  localparam int unsigned EXE_W_SHOP    = 12;
  localparam int unsigned EXE_W_REGADDR = 4;
  localparam int unsigned EXE_W_CMD     = 4;
  localparam int unsigned EXE_W_STATUS  = 4;

  // ALU command encodings
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_MOV = 4'b0001;
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_MVN = 4'b1001;
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_ADD = 4'b0010;
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_ADC = 4'b0011;
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_SUB = 4'b0100;
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_SBC = 4'b0101;
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_AND = 4'b0110;
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_ORR = 4'b0111;
  localparam logic [EXE_W_CMD-1:0] EXE_CMD_EOR = 4'b1000;

  // Register-operand shift types (shift_operand[6:5])
  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  // Forwarding mux selects
  localparam logic [1:0] FWD_SEL_IDEX     = 2'd0;
  localparam logic [1:0] FWD_SEL_MEM      = 2'd1;
  localparam logic [1:0] FWD_SEL_WB       = 2'd2;
  localparam logic [1:0] FWD_SEL_IDEX_ALT = 2'd3;

  // NZCV bit positions
  localparam int unsigned STATUS_N = 3;
  localparam int unsigned STATUS_Z = 2;
  localparam int unsigned STATUS_C = 1;
  localparam int unsigned STATUS_V = 0;

endpackage

// File: rtl/exe_alu.sv
// Combinational execute ALU.
// Ports: op1, val2 - operands; exe_cmd - ALU command; status_in - current NZCV
//        (C feeds ADC/SBC); result - ALU result; status_out - next NZCV.
module exe_alu
  import exe_stage_module_pkg::*;
#(
  parameter int unsigned W = EXE_W_REG
) (
  input  logic [W-1:0]            op1,
  input  logic [W-1:0]            val2,
  input  logic [EXE_W_CMD-1:0]    exe_cmd,
  input  logic [EXE_W_STATUS-1:0] status_in,
  output logic [W-1:0]            result,
  output logic [EXE_W_STATUS-1:0] status_out
);

  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W:0]   sum;
  logic [W-1:0] logic_res;
  logic         is_arith;
  logic         is_valid;

  // All arithmetic shares one adder: subtract is op1 + ~val2 + cin
  assign sum = {1'b0, op1} + {1'b0, add_b} + (W+1)'(add_cin);

  // Command decode: adder operand setup and non-arithmetic results
  always_comb begin
    add_b     = val2;
    add_cin   = 1'b0;
    is_arith  = 1'b0;
    is_valid  = 1'b1;
    logic_res = '0;
    case (exe_cmd)
      EXE_CMD_MOV: logic_res = val2;
      EXE_CMD_MVN: logic_res = ~val2;
      EXE_CMD_ADD: is_arith = 1'b1;
      EXE_CMD_ADC: begin
        is_arith = 1'b1;
        add_cin  = status_in[STATUS_C];
      end
      EXE_CMD_SUB: begin
        is_arith = 1'b1;
        add_b    = ~val2;
        add_cin  = 1'b1;
      end
      EXE_CMD_SBC: begin
        is_arith = 1'b1;
        add_b    = ~val2;
        add_cin  = status_in[STATUS_C];
      end
      EXE_CMD_AND: logic_res = op1 & val2;
      EXE_CMD_ORR: logic_res = op1 | val2;
      EXE_CMD_EOR: logic_res = op1 ^ val2;
      default:     is_valid = 1'b0;
    endcase
  end

  // Result select and flag generation; C/V only move on arithmetic ops
  always_comb begin
    result     = is_arith ? sum[W-1:0] : logic_res;
    status_out = status_in;
    if (is_valid) begin
      status_out[STATUS_N] = result[W-1];
      status_out[STATUS_Z] = (result == '0);
      if (is_arith) begin
        status_out[STATUS_C] = sum[W];
        // Overflow: adder inputs agree in sign, result sign differs
        status_out[STATUS_V] = (op1[W-1] == add_b[W-1]) && (result[W-1] != op1[W-1]);
      end
    end
  end

endmodule

// File: rtl/exe_stage_module.sv
// Execute stage: operand forwarding, Val2 generation, ALU, branch target,
// NZCV status register and the EX/MEM pipeline register.
// Ports:
//   clk, rst (sync, active-low), freeze (hold EX/MEM and status)
//   pc_in, reg_file_out1_in/2_in, signed_immediate_in, shift_operand_in,
//   control bits and execute_command_in, dest_reg_in from ID/EX
//   sel_src1/2, mem_fwd_data, wb_fwd_data from the forwarding unit
//   branch_taken, branch_address  - combinational to IF
//   status_reg_out                - registered NZCV to ID
//   alu_result_out, store_data_out, mem_read_out, mem_write_out,
//   wb_enable_out, dest_reg_out   - EX/MEM register
module exe_stage_module
  import exe_stage_module_pkg::*;
#(
  parameter int unsigned W_REG     = EXE_W_REG,
  parameter int unsigned W_ADDR    = EXE_W_ADDR,
  parameter int unsigned W_IMM24   = EXE_W_IMM24,
  parameter int unsigned W_SHOP    = EXE_W_SHOP,
  parameter int unsigned W_REGADDR = EXE_W_REGADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic [W_ADDR-1:0]       pc_in,
  input  logic [W_REG-1:0]        reg_file_out1_in,
  input  logic [W_REG-1:0]        reg_file_out2_in,
  input  logic [W_IMM24-1:0]      signed_immediate_in,
  input  logic [W_SHOP-1:0]       shift_operand_in,
  input  logic                    is_immediate_in,
  input  logic                    status_write_enable_in,
  input  logic                    mem_read_in,
  input  logic                    mem_write_in,
  input  logic                    wb_enable_in,
  input  logic                    is_branch_in,
  input  logic [EXE_W_CMD-1:0]    execute_command_in,
  input  logic [W_REGADDR-1:0]    dest_reg_in,
  input  logic [1:0]              sel_src1,
  input  logic [1:0]              sel_src2,
  input  logic [W_REG-1:0]        mem_fwd_data,
  input  logic [W_REG-1:0]        wb_fwd_data,
  output logic                    branch_taken,
  output logic [W_ADDR-1:0]       branch_address,
  output logic [EXE_W_STATUS-1:0] status_reg_out,
  output logic [W_REG-1:0]        alu_result_out,
  output logic [W_REG-1:0]        store_data_out,
  output logic                    mem_read_out,
  output logic                    mem_write_out,
  output logic                    wb_enable_out,
  output logic [W_REGADDR-1:0]    dest_reg_out
);

  logic [W_REG-1:0]        op1;
  logic [W_REG-1:0]        src2;
  logic [W_REG-1:0]        val2;
  logic [W_REG-1:0]        alu_result;
  logic [EXE_W_STATUS-1:0] alu_status;
  logic [4:0]              shift_amt;
  logic [1:0]              shift_type;
  logic [4:0]              rot_amt;
  logic [W_REG-1:0]        imm_val;

  // Rotate right by n via a doubled word
  function automatic logic [W_REG-1:0] ror(input logic [W_REG-1:0] x,
                                           input logic [4:0]       n);
    logic [2*W_REG-1:0] dbl;
    dbl = {x, x} >> n;
    return dbl[W_REG-1:0];
  endfunction

  // Forwarding muxes; select 3 falls back to the ID/EX value
  always_comb begin
    op1 = reg_file_out1_in;
    case (sel_src1)
      FWD_SEL_MEM: op1 = mem_fwd_data;
      FWD_SEL_WB:  op1 = wb_fwd_data;
      default:     op1 = reg_file_out1_in;
    endcase
  end

  always_comb begin
    src2 = reg_file_out2_in;
    case (sel_src2)
      FWD_SEL_MEM: src2 = mem_fwd_data;
      FWD_SEL_WB:  src2 = wb_fwd_data;
      default:     src2 = reg_file_out2_in;
    endcase
  end

  assign shift_amt  = shift_operand_in[11:7];
  assign shift_type = shift_operand_in[6:5];
  assign rot_amt    = {shift_operand_in[11:8], 1'b0};
  assign imm_val    = W_REG'(shift_operand_in[7:0]);

  // Val2: memory offset beats rotated immediate beats shifted register
  always_comb begin
    val2 = src2;
    if (mem_read_in || mem_write_in) begin
      val2 = W_REG'(shift_operand_in);
    end else if (is_immediate_in) begin
      val2 = ror(imm_val, rot_amt);
    end else begin
      case (shift_type)
        SHIFT_LSL: val2 = src2 << shift_amt;
        SHIFT_LSR: val2 = src2 >> shift_amt;
        SHIFT_ASR: val2 = W_REG'($signed(src2) >>> shift_amt);
        SHIFT_ROR: val2 = ror(src2, shift_amt);
        default:   val2 = src2;
      endcase
    end
  end

  exe_alu #(
    .W (W_REG)
  ) u_alu (
    .op1        (op1),
    .val2       (val2),
    .exe_cmd    (execute_command_in),
    .status_in  (status_reg_out),
    .result     (alu_result),
    .status_out (alu_status)
  );

  // Branch resolved in ID; EX only forms the word-aligned target
  assign branch_taken   = is_branch_in;
  assign branch_address = pc_in + (W_ADDR'(signed'(signed_immediate_in)) << 2);

  // EX/MEM register and NZCV; reset wins over freeze
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
      wb_enable_out  <= 1'b0;
      dest_reg_out   <= '0;
      status_reg_out <= '0;
    end else if (!freeze) begin
      alu_result_out <= alu_result;
      store_data_out <= src2;
      mem_read_out   <= mem_read_in;
      mem_write_out  <= mem_write_in;
      wb_enable_out  <= wb_enable_in;
      dest_reg_out   <= dest_reg_in;
      if (status_write_enable_in) begin
        status_reg_out <= alu_status;
      end
    end
  end

endmodule
